// File: rtl/srt4_ctrl.sv
// Control FSM for the radix-4 SRT 8-bit divider: sequences normalize, iterate,
// convert, correct and denormalize phases over the c0..c14 datapath strobes.
module srt4_ctrl #(
    parameter int ITERS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       div_zero,
    input  logic       m_msb,
    input  logic       q_pos,
    input  logic       q_neg,
    input  logic       a_neg,
    input  logic [1:0] cnt1,
    input  logic [2:0] cnt2,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       c8,
    output logic       c9,
    output logic       c10,
    output logic       c11,
    output logic       c12,
    output logic       c13,
    output logic       c14,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] dbg_state
);

    // Handshake: start is accepted only on an edge where busy is low (IDLE);
    // the result is signalled by a one-cycle done pulse, with err alongside.
    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_NORM_CHK,
        S_NORM_SHIFT,
        S_ITER_SEL,
        S_ITER_UPD,
        S_CONV,
        S_CORR,
        S_DEN_CHK,
        S_DEN_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_ITER = 2'(ITERS - 1);

    state_t      r_state;
    state_t      w_nxt;
    logic [14:0] r_c;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:       if (start) w_nxt = S_INIT;
            S_INIT:       w_nxt = div_zero ? S_DONE : S_NORM_CHK;
            S_NORM_CHK:   w_nxt = (m_msb || cnt2 == 3'd7) ? S_ITER_SEL : S_NORM_SHIFT;
            S_NORM_SHIFT: w_nxt = S_NORM_CHK;
            S_ITER_SEL:   w_nxt = S_ITER_UPD;
            S_ITER_UPD:   w_nxt = (cnt1 == LAST_ITER) ? S_CONV : S_ITER_SEL;
            S_CONV:       w_nxt = a_neg ? S_CORR : S_DEN_CHK;
            S_CORR:       w_nxt = S_DEN_CHK;
            S_DEN_CHK:    w_nxt = (cnt2 == 3'd0) ? S_DONE : S_DEN_SHIFT;
            S_DEN_SHIFT:  w_nxt = S_DEN_CHK;
            S_DONE:       w_nxt = S_IDLE;
            default:      w_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every port
    // is a flop; the digit sampled in ITER_SEL is captured on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_c     <= '0;
            case (w_nxt)
                S_INIT: begin
                    r_c[0] <= 1'b1;
                    r_c[1] <= 1'b1;
                    r_c[3] <= 1'b1;
                end
                S_NORM_SHIFT: r_c[2] <= 1'b1;
                S_ITER_SEL:   r_c[4] <= 1'b1;
                S_ITER_UPD: begin
                    r_c[5]  <= 1'b1;
                    r_c[11] <= 1'b1;
                    // Both digit flags high is a datapath fault; positive wins.
                    if (q_pos) begin
                        r_c[6] <= 1'b1;
                        r_c[8] <= 1'b1;
                    end else if (q_neg) begin
                        r_c[7] <= 1'b1;
                        r_c[9] <= 1'b1;
                    end
                end
                S_CONV:      r_c[10] <= 1'b1;
                S_CORR:      r_c[12] <= 1'b1;
                S_DEN_SHIFT: r_c[14] <= 1'b1;
                S_DONE:      r_c[13] <= 1'b1;
                default:     ;
            endcase
            r_busy <= (w_nxt != S_IDLE);
            r_done <= (w_nxt == S_DONE);
            if (w_nxt == S_INIT) begin
                r_err <= 1'b0;
            end else if (r_state == S_INIT && w_nxt == S_DONE) begin
                r_err <= 1'b1;
            end
        end
    end

    assign c0        = r_c[0];
    assign c1        = r_c[1];
    assign c2        = r_c[2];
    assign c3        = r_c[3];
    assign c4        = r_c[4];
    assign c5        = r_c[5];
    assign c6        = r_c[6];
    assign c7        = r_c[7];
    assign c8        = r_c[8];
    assign c9        = r_c[9];
    assign c10       = r_c[10];
    assign c11       = r_c[11];
    assign c12       = r_c[12];
    assign c13       = r_c[13];
    assign c14       = r_c[14];
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_srt4_ctrl.sv
// Bench for srt4_ctrl: models the counters and divisor register around the
// controller and checks each division against latency and strobe expectations.
module tb_srt4_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       div_zero;
    logic       m_msb;
    logic       q_pos;
    logic       q_neg;
    logic       a_neg = 1'b0;
    logic [1:0] cnt1;
    logic [2:0] cnt2;
    logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14;
    logic       busy, done, err;
    logic [3:0] dbg_state;

    logic [7:0] divisor_in = 8'd0;
    logic [1:0] digs[4] = '{2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] m_cnt1 = 2'd0;
    logic [2:0] m_cnt2 = 3'd0;
    logic [7:0] m_reg = 8'd0;
    logic [1:0] w_dig;
    logic [3:0] exp_q[$];
    int         cyc;
    int         n_chk = 0;
    int         n_pass = 0;

    srt4_ctrl #(.ITERS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .div_zero(div_zero),
        .m_msb(m_msb), .q_pos(q_pos), .q_neg(q_neg), .a_neg(a_neg),
        .cnt1(cnt1), .cnt2(cnt2),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
        .c7(c7), .c8(c8), .c9(c9), .c10(c10), .c11(c11), .c12(c12),
        .c13(c13), .c14(c14), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Datapath side: counters and divisor register respond to the strobes.
    always @(posedge clk) begin
        if (c0) begin
            m_cnt1 <= 2'd0;
            m_cnt2 <= 3'd0;
        end else begin
            if (c11) m_cnt1 <= m_cnt1 + 2'd1;
            if (c2) m_cnt2 <= m_cnt2 + 3'd1;
            else if (c14) m_cnt2 <= m_cnt2 - 3'd1;
        end
        if (c3) m_reg <= divisor_in;
        else if (c2) m_reg <= {m_reg[6:0], 1'b0};
    end

    assign cnt1     = m_cnt1;
    assign cnt2     = m_cnt2;
    assign m_msb    = m_reg[7];
    assign div_zero = (divisor_in == 8'd0);
    assign w_dig    = digs[m_cnt1];
    assign q_pos    = w_dig[0];
    assign q_neg    = w_dig[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    function automatic logic [17:0] all_outs();
        return {c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, busy, done, err};
    endfunction

    task automatic run_div(input logic [7:0] dv, input logic an, input logic [1:0] d0,
                           input logic [1:0] d1, input logic [1:0] d2, input logic [1:0] d3,
                           input bit hold);
        int k = 0;
        int d_exp;
        int done_cyc = -1;
        int busy_cnt = 0;
        int n2 = 0, n11 = 0, n12 = 0, n14 = 0, viol = 0;
        logic p2 = 1'b0, p11 = 1'b0, p14 = 1'b0;
        logic c0_d1 = 1'b1, c0_d2 = 1'b0, busy_d1 = 1'b1, err_d = 1'b0, err_c1 = 1'b1;
        logic [2:0] init_v = 3'd0;
        logic [1:0] dl[4];
        dl = '{d0, d1, d2, d3};
        // Normalization shifts = leading zeros of the divisor, capped at 7.
        if (dv != 8'd0) while (k < 7 && !dv[7-k]) k++;
        d_exp = (dv == 8'd0) ? 2 : 13 + 4 * k + int'(an);
        exp_q.delete();
        if (dv != 8'd0)
            for (int i = 0; i < 4; i++)
                exp_q.push_back(dl[i][0] ? 4'b1010 : (dl[i][1] ? 4'b0101 : 4'b0000));
        @(negedge clk);
        divisor_in = dv;
        a_neg = an;
        digs = dl;
        start = 1'b1;
        cyc = 0;
        while (cyc < 150 && (done_cyc < 0 || cyc < done_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (cyc == 1) begin
                init_v = {c0, c1, c3};
                err_c1 = err;
            end
            if (done_cyc < 0) begin
                busy_cnt += int'(busy);
                n2  += int'(c2);
                n11 += int'(c11);
                n12 += int'(c12);
                n14 += int'(c14);
                if ((c2 && p2) || (c11 && p11) || (c14 && p14)) viol++;
                if (c0 && (c2 || c11 || c14)) viol++;
                if (c11 && c4) viol++;
                if (c11) begin
                    if (exp_q.size() > 0) chk("digit_ctrl", {28'd0, c6, c7, c8, c9}, exp_q.pop_front());
                    else chk("c11_extra", 1, 0);
                end
                if (done) begin
                    done_cyc = cyc;
                    err_d = err;
                end
            end else if (cyc == done_cyc + 1) begin
                busy_d1 = busy;
                c0_d1 = c0;
            end else begin
                c0_d2 = c0;
            end
            p2 = c2;
            p11 = c11;
            p14 = c14;
        end
        chk("done_cycle", done_cyc, d_exp);
        chk("init_c0c1c3", init_v, 3'b111);
        chk("err_cleared_init", err_c1, 0);
        chk("err_at_done", err_d, (dv == 8'd0));
        chk("c2_count", n2, k);
        chk("c14_count", n14, k);
        chk("c12_count", n12, (dv == 8'd0) ? 0 : int'(an));
        chk("c11_count", n11, (dv == 8'd0) ? 0 : 4);
        chk("digits_left", exp_q.size(), 0);
        chk("pulse_rules", viol, 0);
        chk("busy_cycles", busy_cnt, d_exp);
        chk("busy_after_done", busy_d1, 0);
        chk("c0_after_done", c0_d1, 0);
        chk("c0_restart", c0_d2, hold);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_seen;
        int sh;
        logic [7:0] top, dv;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 18'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(8'h80, 1'b0, 2'd1, 2'd0, 2'd2, 2'd1, 1'b0);
        run_div(8'h10, 1'b1, 2'd2, 2'd2, 2'd1, 2'd0, 1'b0);
        run_div(8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_hold", err, 1);
        chk("busy_idle", busy, 0);
        run_div(8'h03, 1'b0, 2'd3, 2'd1, 2'd2, 2'd3, 1'b0);

        // Reset during the second normalization shift of a k=3 division.
        @(negedge clk);
        divisor_in = 8'h10;
        start = 1'b1;
        n_seen = 0;
        for (int i = 0; i < 40 && n_seen < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (c2) n_seen++;
        end
        chk("rst_mid_reached", n_seen, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", all_outs(), 18'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", all_outs(), 18'd0);
        run_div(8'h10, 1'b1, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0);

        run_div(8'h40, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b1);
        do_reset(2);
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            sh = $urandom_range(0, 7);
            top = 8'h80 >> sh;
            dv = top | (8'($urandom) & (top - 8'd1));
            if ($urandom_range(0, 7) == 0) dv = 8'h00;
            run_div(dv, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
